// File: rtl/cakegame_pkg.sv
// Cake memory game: shared FSM encoding and display-select constants.
// Imported by cakegame_seq_ctrl and cakegame_step_counter.
package cakegame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'h0,
        ST_PREP       = 4'h1,
        ST_START_SHOW = 4'h2,
        ST_SHOW_PLAY  = 4'h3,
        ST_SHOW_GAP   = 4'h4,
        ST_NEXT_SHOW  = 4'h5,
        ST_REG_SHOW   = 4'h6,
        ST_INIT_PLAY  = 4'h7,
        ST_WAIT_PLAY  = 4'h8,
        ST_REG_PLAY   = 4'h9,
        ST_CMP_PLAY   = 4'hA,
        ST_NEXT_PLAY  = 4'hB,
        ST_ROUND_DONE = 4'hC,
        ST_MISS       = 4'hD,
        ST_END        = 4'hE
    } state_t;

    localparam logic [1:0] OUT_SEL_IDLE = 2'b00;
    localparam logic [1:0] OUT_SEL_SHOW = 2'b01;
    localparam logic [1:0] OUT_SEL_PLAY = 2'b10;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_LIVES   = 3;

endpackage

// File: rtl/cakegame_step_counter.sv
// Up-counter with clear, load and increment (clear > load > enable),
// plus an equality flag against a terminal value.
// Ports: clock, reset (async, high), clear, load, load_value, enable,
//        term, count, at_term.
module cakegame_step_counter
    import cakegame_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (load)   count <= load_value;
        else if (enable) count <= count + 1'b1;
    end

    assign at_term = (count == term);

endmodule

// File: rtl/cakegame_seq_ctrl.sv
// Cake memory game sequencer: show phase, play phase, lives and points.
// Inputs: clock, reset (async, high), start, mode, has_play,
//   correct_play, half_show, end_show, timeout.
// Outputs: mem_addr, round_len, lives_left, points, out_sel, register /
//   RAM / counter controls, reset_random, fast_show, finished, won, state.
// Optional macro CAKEGAME_SPEEDUP_EN enables fast_show.
module cakegame_seq_ctrl
    import cakegame_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int ADDR_W      = 4,
    parameter int LIVES       = DEF_LIVES,
    parameter int POINTS_W    = 8,
    parameter int SPEEDUP_LEN = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic                has_play,
    input  logic                correct_play,
    input  logic                half_show,
    input  logic                end_show,
    input  logic                timeout,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [ADDR_W:0]     round_len,
    output logic [2:0]          lives_left,
    output logic [POINTS_W-1:0] points,
    output logic [1:0]          out_sel,
    output logic                clear_reg,
    output logic                enable_reg,
    output logic                clear_ram,
    output logic                ram_we,
    output logic                clear_show_counter,
    output logic                enable_show_counter,
    output logic                clear_timeout_counter,
    output logic                enable_timeout_counter,
    output logic                reset_random,
    output logic                fast_show,
    output logic                finished,
    output logic                won,
    output logic [3:0]          state
);

    localparam logic [ADDR_W:0] MAX_LEN_W = MAX_LEN[ADDR_W:0];
    localparam logic [2:0]      LIVES_W   = LIVES[2:0];

    state_t st, nxt;

    logic              mode_q;
    logic              replay;
    logic              addr_clr, addr_inc, addr_last;
    logic              rl_load, rl_inc, rl_is_max;
    logic              write_ok;
    logic [ADDR_W:0]   rl_init;
    logic [ADDR_W-1:0] last_addr;

    // round_len >= 1 whenever the step index is compared against it
    assign last_addr = ADDR_W'(round_len - 1'b1);
    assign rl_init   = mode ? (ADDR_W+1)'(1) : MAX_LEN_W;

    // Progressive rounds add only their newest step; replays write nothing
    assign write_ok = !replay && (!mode_q || addr_last);

    cakegame_step_counter #(.W(ADDR_W)) u_addr (
        .clock      (clock),
        .reset      (reset),
        .clear      (addr_clr),
        .load       (1'b0),
        .load_value ('0),
        .enable     (addr_inc),
        .term       (last_addr),
        .count      (mem_addr),
        .at_term    (addr_last)
    );

    cakegame_step_counter #(.W(ADDR_W+1)) u_round_len (
        .clock      (clock),
        .reset      (reset),
        .clear      (1'b0),
        .load       (rl_load),
        .load_value (rl_init),
        .enable     (rl_inc),
        .term       (MAX_LEN_W),
        .count      (round_len),
        .at_term    (rl_is_max)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) st <= ST_IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt                    = st;
        out_sel                = OUT_SEL_IDLE;
        clear_reg              = 1'b0;
        enable_reg             = 1'b0;
        clear_ram              = 1'b0;
        ram_we                 = 1'b0;
        clear_show_counter     = 1'b0;
        enable_show_counter    = 1'b0;
        clear_timeout_counter  = 1'b0;
        enable_timeout_counter = 1'b0;
        reset_random           = 1'b0;
        finished               = 1'b0;
        addr_inc               = 1'b0;
        rl_load                = 1'b0;
        rl_inc                 = 1'b0;
        case (st)
            ST_IDLE: begin
                clear_show_counter = 1'b1;
                if (start) nxt = ST_PREP;
            end
            ST_PREP: begin
                clear_reg           = 1'b1;
                clear_ram           = 1'b1;
                reset_random        = 1'b1;
                enable_show_counter = 1'b1;
                rl_load             = 1'b1;
                if (half_show) nxt = ST_START_SHOW;
            end
            ST_START_SHOW: begin
                clear_show_counter = 1'b1;
                ram_we             = write_ok;
                nxt                = ST_SHOW_PLAY;
            end
            ST_SHOW_PLAY: begin
                out_sel             = OUT_SEL_SHOW;
                enable_show_counter = 1'b1;
                if (half_show) nxt = ST_SHOW_GAP;
            end
            ST_SHOW_GAP: begin
                enable_show_counter = 1'b1;
                if (end_show) nxt = ST_NEXT_SHOW;
            end
            ST_NEXT_SHOW: begin
                if (addr_last) begin
                    nxt = ST_INIT_PLAY;
                end else begin
                    addr_inc = 1'b1;
                    nxt      = ST_REG_SHOW;
                end
            end
            ST_REG_SHOW: begin
                ram_we = write_ok;
                nxt    = ST_SHOW_PLAY;
            end
            ST_INIT_PLAY: begin
                clear_timeout_counter = 1'b1;
                nxt                   = ST_WAIT_PLAY;
            end
            ST_WAIT_PLAY: begin
                out_sel                = OUT_SEL_PLAY;
                enable_timeout_counter = 1'b1;
                if (has_play)     nxt = ST_REG_PLAY;
                else if (timeout) nxt = ST_MISS;
            end
            ST_REG_PLAY: begin
                out_sel    = OUT_SEL_PLAY;
                enable_reg = 1'b1;
                nxt        = ST_CMP_PLAY;
            end
            ST_CMP_PLAY: begin
                out_sel = OUT_SEL_PLAY;
                nxt     = correct_play ? ST_NEXT_PLAY : ST_MISS;
            end
            ST_NEXT_PLAY: begin
                out_sel               = OUT_SEL_PLAY;
                clear_timeout_counter = 1'b1;
                if (addr_last) begin
                    nxt = ST_ROUND_DONE;
                end else begin
                    addr_inc = 1'b1;
                    nxt      = ST_WAIT_PLAY;
                end
            end
            ST_ROUND_DONE: begin
                if (rl_is_max) begin
                    nxt = ST_END;
                end else begin
                    rl_inc = 1'b1;
                    nxt    = ST_START_SHOW;
                end
            end
            ST_MISS: begin
                nxt = (lives_left == 3'd1) ? ST_END : ST_START_SHOW;
            end
            ST_END: begin
                finished           = 1'b1;
                clear_show_counter = 1'b1;
                if (start) nxt = ST_PREP;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Both targets exit after one cycle, so this fires only on entry
    assign addr_clr = (nxt == ST_START_SHOW) || (nxt == ST_INIT_PLAY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q     <= 1'b0;
            lives_left <= LIVES_W;
            points     <= '0;
            replay     <= 1'b0;
            won        <= 1'b0;
        end else begin
            case (st)
                ST_PREP: begin
                    mode_q     <= mode;
                    lives_left <= LIVES_W;
                    points     <= '0;
                    replay     <= 1'b0;
                    won        <= 1'b0;
                end
                ST_NEXT_PLAY: begin
                    if (points != '1) points <= points + 1'b1;
                end
                ST_ROUND_DONE: begin
                    if (rl_is_max) won <= 1'b1;
                    else           replay <= 1'b0;
                end
                ST_MISS: begin
                    lives_left <= lives_left - 3'd1;
                    if (lives_left != 3'd1) replay <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CAKEGAME_SPEEDUP_EN
    localparam logic [ADDR_W:0] SPEED_LEN_W = SPEEDUP_LEN[ADDR_W:0];

    logic show_phase;
    assign show_phase = st inside {ST_START_SHOW, ST_SHOW_PLAY,
                                   ST_SHOW_GAP, ST_NEXT_SHOW,
                                   ST_REG_SHOW};
    assign fast_show = show_phase && (round_len >= SPEED_LEN_W);
`else
    logic [ADDR_W:0] unused_speedup;
    assign unused_speedup = SPEEDUP_LEN[ADDR_W:0];
    assign fast_show      = 1'b0;
`endif

    assign state = st;

endmodule

// File: tb/tb_cakegame_seq_ctrl.sv
// Testbench for cakegame_seq_ctrl: reactive player/counter model,
// scenario table, RAM-write scoreboard and multi-cycle corner cases.
module tb_cakegame_seq_ctrl;
    import cakegame_pkg::*;

    localparam int MAX_LEN     = 4;
    localparam int ADDR_W      = 2;
    localparam int LIVES       = 3;
    localparam int POINTS_W    = 8;
    localparam int SPEEDUP_LEN = 2;

    localparam logic [1:0] A_C = 2'd0;
    localparam logic [1:0] A_W = 2'd1;
    localparam logic [1:0] A_T = 2'd2;
    localparam logic [1:0] A_B = 2'd3;

`ifdef CAKEGAME_SPEEDUP_EN
    localparam logic FS_EXP = 1'b1;
`else
    localparam logic FS_EXP = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic                start;
    logic                mode;
    logic                has_play;
    logic                correct_play;
    logic                half_show;
    logic                end_show;
    logic                timeout;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ADDR_W:0]     round_len;
    logic [2:0]          lives_left;
    logic [POINTS_W-1:0] points;
    logic [1:0]          out_sel;
    logic                clear_reg;
    logic                enable_reg;
    logic                clear_ram;
    logic                ram_we;
    logic                clear_show_counter;
    logic                enable_show_counter;
    logic                clear_timeout_counter;
    logic                enable_timeout_counter;
    logic                reset_random;
    logic                fast_show;
    logic                finished;
    logic                won;
    logic [3:0]          state;

    cakegame_seq_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .ADDR_W      (ADDR_W),
        .LIVES       (LIVES),
        .POINTS_W    (POINTS_W),
        .SPEEDUP_LEN (SPEEDUP_LEN)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .mode                   (mode),
        .has_play               (has_play),
        .correct_play           (correct_play),
        .half_show              (half_show),
        .end_show               (end_show),
        .timeout                (timeout),
        .mem_addr               (mem_addr),
        .round_len              (round_len),
        .lives_left             (lives_left),
        .points                 (points),
        .out_sel                (out_sel),
        .clear_reg              (clear_reg),
        .enable_reg             (enable_reg),
        .clear_ram              (clear_ram),
        .ram_we                 (ram_we),
        .clear_show_counter     (clear_show_counter),
        .enable_show_counter    (enable_show_counter),
        .clear_timeout_counter  (clear_timeout_counter),
        .enable_timeout_counter (enable_timeout_counter),
        .reset_random           (reset_random),
        .fast_show              (fast_show),
        .finished               (finished),
        .won                    (won),
        .state                  (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        logic [31:0] acts;
        int          writes;
        int          pts;
        logic        won;
        int          lives;
        int          rl;
    } vec_t;

    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       acts;
    logic [1:0]        last_act;
    logic [1:0]        act;
    int                play_idx;
    int                play_limit;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_state(input state_t s, input int budget);
        int n;
        n = 0;
        while (state != s && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (state != s) begin
            errors++;
            $display("FAIL wait_%s got %0h want %0h", s.name(), state, s);
        end
    endtask

    // Player, show counter and timeout counter reacting to the DUT state
    initial begin
        half_show    = 1'b0;
        end_show     = 1'b0;
        has_play     = 1'b0;
        timeout      = 1'b0;
        correct_play = 1'b0;
        last_act     = A_C;
        forever begin
            @(negedge clock);
            half_show = (state == ST_PREP) || (state == ST_SHOW_PLAY);
            end_show  = (state == ST_SHOW_GAP);
            has_play  = 1'b0;
            timeout   = 1'b0;
            if (state == ST_WAIT_PLAY && play_idx < play_limit) begin
                act      = (play_idx < 16) ? acts[2*play_idx +: 2] : A_C;
                last_act = act;
                play_idx++;
                has_play = (act != A_T);
                timeout  = (act == A_T) || (act == A_B);
            end
            correct_play = (last_act == A_C) || (last_act == A_B);
        end
    end

    // RAM write scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (ram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ram_we got addr %0d want none", mem_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    chk("ram_addr", 32'(mem_addr), 32'(exp_addr));
                end
            end
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'(i));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int r);
        mode       = v.mode;
        acts       = v.acts;
        play_idx   = 0;
        play_limit = 1000;
        push_writes(v.writes);
        pulse_start();
        wait_state(ST_END, 4000);
        chk($sformatf("r%0d_points", r), 32'(points), 32'(v.pts));
        chk($sformatf("r%0d_won", r), 32'(won), 32'(v.won));
        chk($sformatf("r%0d_lives", r), 32'(lives_left), 32'(v.lives));
        chk($sformatf("r%0d_rlen", r), 32'(round_len), 32'(v.rl));
        chk($sformatf("r%0d_fin", r), 32'(finished), 32'(1));
        chk($sformatf("r%0d_wleft", r), 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0000, 4, 4, 1'b1, 3, 4};
        tbl[1] = '{1'b1, 32'h0000_0000, 4, 10, 1'b1, 3, 4};
        tbl[2] = '{1'b1, 32'h0000_0015, 1, 0, 1'b0, 0, 1};
        tbl[3] = '{1'b1, 32'h0000_0010, 4, 11, 1'b1, 2, 4};
        tbl[4] = '{1'b0, 32'h0000_002A, 4, 0, 1'b0, 0, 4};
        tbl[5] = '{1'b0, 32'h0000_00FF, 4, 4, 1'b1, 3, 4};
        tbl[6] = '{1'b0, 32'h0000_0040, 4, 7, 1'b1, 2, 4};

        reset      = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        acts       = '0;
        play_idx   = 0;
        play_limit = 1000;
        repeat (2) @(negedge clock);

        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_rlen", 32'(round_len), 32'(0));
        chk("rst_lives", 32'(lives_left), 32'(LIVES));
        chk("rst_points", 32'(points), 32'(0));
        chk("rst_won", 32'(won), 32'(0));
        chk("rst_fin", 32'(finished), 32'(0));
        chk("rst_clrshow", 32'(clear_show_counter), 32'(1));
        chk("rst_outsel", 32'(out_sel), 32'(OUT_SEL_IDLE));

        reset = 1'b0;
        @(negedge clock);

        for (int r = 0; r < 7; r++) run_row(tbl[r], r);

        // Restart from END, progressive, watch fast_show across rounds
        mode       = 1'b1;
        acts       = '0;
        play_idx   = 0;
        play_limit = 1000;
        push_writes(4);
        pulse_start();
        chk("end_start_prep", 32'(state), 32'(ST_PREP));
        @(negedge clock);
        chk("prep_points", 32'(points), 32'(0));
        chk("prep_lives", 32'(lives_left), 32'(LIVES));
        wait_state(ST_SHOW_PLAY, 100);
        chk("r1_fast", 32'(fast_show), 32'(0));
        chk("r1_outsel", 32'(out_sel), 32'(OUT_SEL_SHOW));
        chk("r1_rlen", 32'(round_len), 32'(1));
        wait_state(ST_INIT_PLAY, 200);
        wait_state(ST_SHOW_PLAY, 200);
        chk("r2_rlen", 32'(round_len), 32'(2));
        chk("r2_fast", 32'(fast_show), 32'(FS_EXP));
        wait_state(ST_END, 4000);
        chk("fs_won", 32'(won), 32'(1));
        chk("fs_points", 32'(points), 32'(10));
        chk("fs_wleft", 32'(exp_q.size()), 32'(0));
        exp_q.delete();

        // Reset while waiting for the third play of a fixed game
        mode       = 1'b0;
        acts       = '0;
        play_idx   = 0;
        play_limit = 2;
        push_writes(4);
        pulse_start();
        wait_state(ST_WAIT_PLAY, 500);
        wait_state(ST_REG_PLAY, 50);
        wait_state(ST_WAIT_PLAY, 50);
        wait_state(ST_REG_PLAY, 50);
        wait_state(ST_WAIT_PLAY, 50);
        repeat (3) @(negedge clock);
        chk("wait_state", 32'(state), 32'(ST_WAIT_PLAY));
        chk("wait_outsel", 32'(out_sel), 32'(OUT_SEL_PLAY));
        chk("wait_en_to", 32'(enable_timeout_counter), 32'(1));
        chk("wait_addr", 32'(mem_addr), 32'(2));
        chk("wait_points", 32'(points), 32'(2));
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(ST_IDLE));
        @(negedge clock);
        chk("arst_addr", 32'(mem_addr), 32'(0));
        chk("arst_rlen", 32'(round_len), 32'(0));
        chk("arst_points", 32'(points), 32'(0));
        chk("arst_lives", 32'(lives_left), 32'(LIVES));
        chk("arst_wleft", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
